ins_mem_ctrl: RTL and testbench
===============================

// Module: ins_mem_ctrl
// PURPOSE
//  Next-generation instruction memory for the CPU fetch stage. Width and depth are parameters.
//  After reset it self-initialises from a built-in boot image, one word per cycle.
//  Fetch uses a registered req/valid port; a streaming program-load port lets the test
//  bench or a loader rewrite the contents at run time.
// PARAMETERS
//  DATA_W   8   instruction width in bits
//  ADDR_W   4   fetch/program address width
//  DEPTH   16   number of words implemented, 1..2**ADDR_W
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  fetch_req    in   1       fetch request; sampled only when fetch_ready=1
//  fetch_addr   in   ADDR_W  word address of the fetch
//  fetch_ready  out  1       1 only in state RUN
//  fetch_valid  out  1       1-cycle pulse; fetch_instr/fetch_err are valid this cycle
//  fetch_instr  out  DATA_W  fetched word; holds its value between fetches
//  fetch_err    out  1       with fetch_valid: fetch_addr >= DEPTH (fetch_instr = 0)
//  prog_start   in   1       in RUN: enter LOAD, write pointer := 0
//  prog_wr      in   1       in LOAD: write prog_data at the pointer, pointer+1
//  prog_data    in   DATA_W  word to program
//  prog_last    in   1       with prog_wr: final word; return to RUN next cycle
//  prog_busy    out  1       1 in states INIT and LOAD
//  prog_count   out  ADDR_W+1  words written in the current/last LOAD
//  init_done    out  1       sticky 1 once INIT completes; cleared by rst
// BEHAVIOUR
//  Reset (async assert): state=INIT, init counter=0, fetch_valid=0, fetch_instr=0,
//   fetch_err=0, prog_count=0, init_done=0, prog_busy=1, fetch_ready=0.
//   Memory contents are not reset directly; INIT rewrites them.
//  FSM INIT -> RUN -> LOAD -> RUN.
//  INIT: each cycle writes boot_image(cnt) to mem[cnt] and increments cnt.
//   After the write of cnt=DEPTH-1: next state RUN, init_done=1. INIT takes exactly DEPTH cycles.
//  Boot image: word i = {0,2,4,16,32,64,128,255,0,100,0,200}[i] for i<12, else 0.
//   Each word is truncated/zero-extended to DATA_W. Words beyond DEPTH are dropped.
//  RUN fetch: fetch_req=1 at edge N -> fetch_valid=1 in cycle N+1 with mem[fetch_addr]
//   (1-cycle latency). Back-to-back requests give one result per cycle. Out of range:
//   fetch_err=1 and fetch_instr=0.
//  RUN: prog_start=1 takes priority over fetch_req in the same cycle. The fetch is dropped,
//   not queued; fetch_valid=0 next cycle. Next state LOAD, pointer=0, prog_count=0.
//  LOAD: prog_wr writes mem[ptr], ptr++, prog_count++. ptr saturates at DEPTH:
//   further writes are ignored and prog_count stops at DEPTH.
//   prog_wr and prog_last together -> that word is written, next state RUN.
//   prog_last without prog_wr is ignored. prog_start in LOAD is ignored.
//  In INIT/LOAD, fetch_req is ignored and fetch_valid=0. prog_* inputs in INIT are ignored.
//  A write and a read never collide: reads occur only in RUN, writes only in INIT/LOAD.
//  rst mid-LOAD or mid-INIT: immediate return to INIT. The whole image is reloaded and
//   partially programmed words are overwritten.
// STRUCTURE
//  Shared package cpu_pkg: state enum {INIT,RUN,LOAD}; boot-image table as a constant
//   function boot_word(idx) used by this block and the bench reference model.
//  One sub-module: ins_mem_array (DATA_W x DEPTH). 1 write port, 1 registered read port,
//   no reset. Maps to block RAM.
//  FSM, init counter, write pointer and response registers stay in ins_mem_ctrl.
// TESTING
//  1 rst pulse, defaults -> prog_busy=1 for exactly 16 cycles, then init_done=1, fetch_ready=1.
//  2 after INIT, fetch addr 5 then 6 back-to-back -> fetch_valid two consecutive cycles,
//    fetch_instr=64 then 128.
//  3 LOAD: prog_start, then write 0xA1,0xA2,0xA3 (prog_last on 3rd) -> prog_count=3, RUN.
//    Fetch 0..3 -> A1,A2,A3,16.
//  4 DEPTH=12, ADDR_W=4: fetch addr 13 -> fetch_err=1, fetch_instr=0. Fetch 11 -> 200.
//  5 LOAD with 20 writes at DEPTH=16 -> prog_count saturates at 16. Fetch 15 returns write #16.
//  6 rst asserted mid-LOAD after 2 writes -> INIT repeats. Fetch 0,1 -> 0,2.
//    Also same-cycle prog_start+fetch_req -> no fetch_valid.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction memory: controller state encoding
// and the built-in boot image used to initialise memory after reset.
package cpu_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int unsigned BOOT_WORDS = 12;

    // Boot image word for a given index. The value is returned as 32 bits and
    // the caller truncates or zero-extends it to its own data width.
    function automatic int unsigned boot_word(input int unsigned idx);
        int unsigned w;
        w = 0;
        case (idx)
            0:  w = 0;
            1:  w = 2;
            2:  w = 4;
            3:  w = 16;
            4:  w = 32;
            5:  w = 64;
            6:  w = 128;
            7:  w = 255;
            8:  w = 0;
            9:  w = 100;
            10: w = 0;
            11: w = 200;
            default: w = 0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ins_mem_ctrl_if.sv
// Fetch and program-load signal bundle between a CPU/loader (master) and the
// instruction memory controller (slave).
//
// Fetch handshake: the master raises fetch_req with fetch_addr. The request is
// taken on a rising edge only while fetch_ready=1. Every taken request yields
// exactly one fetch_valid pulse on the following cycle. There is no
// back-pressure on the response, and a request made while fetch_ready=0 is
// dropped, not queued.
interface ins_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;
    logic              prog_start;
    logic              prog_wr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_busy;
    logic [ADDR_W:0]   prog_count;
    logic              init_done;

    modport master (
        output fetch_req, fetch_addr, prog_start, prog_wr, prog_data, prog_last,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_err,
               prog_busy, prog_count, init_done
    );

    modport slave (
        input  fetch_req, fetch_addr, prog_start, prog_wr, prog_data, prog_last,
        output fetch_ready, fetch_valid, fetch_instr, fetch_err,
               prog_busy, prog_count, init_done
    );
endinterface

// File: rtl/ins_mem_ctrl_array.sv
// Instruction storage: one write port and one registered read port, with no
// reset, so that it maps onto block RAM.
module ins_mem_ctrl_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write; the controller only issues in-range addresses.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; rdata holds its value between reads.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ins_mem_ctrl.sv
// Instruction memory controller: self-initialises from the boot image after
// reset, serves single-cycle-latency fetches in RUN, and accepts streamed
// program loads in LOAD.
module ins_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ins_mem_ctrl_if.slave        bus,
    output state_t               dbg_state
);
    localparam int unsigned     DEPTH_U  = DEPTH;
    localparam int unsigned     LAST_U   = DEPTH - 1;
    localparam logic [ADDR_W:0] DEPTH_W  = DEPTH_U[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_IDX = LAST_U[ADDR_W:0];

    state_t            state, state_nxt;
    logic [ADDR_W:0]   init_cnt;
    logic [ADDR_W:0]   prog_count;
    logic              init_done;
    logic              fetch_valid, fetch_err, have_data;
    logic              fetch_acc, fetch_oob, load_wr;
    logic              we, re;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, rdata;

    // prog_start wins over a same-cycle fetch; the fetch is simply dropped.
    assign fetch_oob = {1'b0, bus.fetch_addr} >= DEPTH_W;
    assign fetch_acc = (state == RUN) && bus.fetch_req && !bus.prog_start;
    assign load_wr   = (state == LOAD) && bus.prog_wr && (prog_count < DEPTH_W);
    assign re        = fetch_acc && !fetch_oob;

    // Next-state logic and write-port steering (boot image in INIT, loader in LOAD).
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        case (state)
            INIT: begin
                we    = 1'b1;
                waddr = init_cnt[ADDR_W-1:0];
                wdata = DATA_W'(boot_word(32'(init_cnt)));
                if (init_cnt == LAST_IDX) state_nxt = RUN;
            end
            RUN: begin
                if (bus.prog_start) state_nxt = LOAD;
            end
            LOAD: begin
                we    = load_wr;
                waddr = prog_count[ADDR_W-1:0];
                wdata = bus.prog_data;
                if (bus.prog_wr && bus.prog_last) state_nxt = RUN;
            end
            default: state_nxt = INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Boot counter and sticky init-complete flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_IDX) init_done <= 1'b1;
        end
    end

    // Load pointer, which doubles as the count of words written; saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 prog_count <= '0;
        else if (state == RUN && bus.prog_start) prog_count <= '0;
        else if (load_wr)                        prog_count <= prog_count + 1'b1;
    end

    // Fetch response registers; have_data masks the unreset RAM output until a real read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            have_data   <= 1'b0;
        end else begin
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fetch_err <= fetch_oob;
                have_data <= have_data | !fetch_oob;
            end
        end
    end

    ins_mem_ctrl_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    assign bus.fetch_ready = (state == RUN);
    assign bus.prog_busy   = (state != RUN);
    assign bus.prog_count  = prog_count;
    assign bus.init_done   = init_done;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_err   = fetch_err;
    assign bus.fetch_instr = (have_data && !fetch_err) ? rdata : '0;
    assign dbg_state       = state;
endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Directed bench for ins_mem_ctrl: a DEPTH=16 instance for the main flows and a
// DEPTH=12 instance for the out-of-range fetch boundary.
module tb_ins_mem_ctrl;
    import cpu_pkg::*;

    logic   clk;
    logic   rst;
    state_t st16, st12;
    int     vectors;
    int     miscompares;
    int     c16, c12;

    ins_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) i16 ();
    ins_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) i12 ();

    ins_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .bus(i16), .dbg_state(st16));
    ins_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut12 (
        .clk(clk), .rst(rst), .bus(i12), .dbg_state(st12));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle_all;
        @(negedge clk);
        i16.fetch_req = 0; i16.prog_start = 0; i16.prog_wr = 0; i16.prog_last = 0;
        i12.fetch_req = 0; i12.prog_start = 0; i12.prog_wr = 0; i12.prog_last = 0;
    endtask

    task automatic fetch16(input logic [3:0] a);
        @(negedge clk);
        i16.fetch_req = 1; i16.fetch_addr = a;
        @(posedge clk); #1;
    endtask

    task automatic fetch12(input logic [3:0] a);
        @(negedge clk);
        i12.fetch_req = 1; i12.fetch_addr = a;
        @(posedge clk); #1;
    endtask

    task automatic prog_begin;
        @(negedge clk);
        i16.fetch_req = 0; i16.prog_start = 1;
        @(posedge clk); #1;
    endtask

    task automatic prog_write(input logic [7:0] d, input logic last);
        @(negedge clk);
        i16.prog_start = 0; i16.prog_wr = 1; i16.prog_data = d; i16.prog_last = last;
        @(posedge clk); #1;
    endtask

    task automatic release_reset(output int n16, output int n12);
        n16 = -1; n12 = -1;
        @(negedge clk);
        rst = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (n16 < 0 && !i16.prog_busy) n16 = i;
            if (n12 < 0 && !i12.prog_busy) n12 = i;
        end
    endtask

    // scenarios
    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (i16.prog_busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b want 1", i16.prog_busy); end
        vectors++; if (i16.fetch_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", i16.fetch_ready); end
        vectors++; if (i16.init_done !== 1'b0) begin miscompares++; $display("FAIL rst_init_done: got %b want 0", i16.init_done); end
        vectors++; if (i16.fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", i16.fetch_valid); end
        vectors++; if (i16.fetch_instr !== 8'h00) begin miscompares++; $display("FAIL rst_instr: got %h want 00", i16.fetch_instr); end
        vectors++; if (i16.prog_count !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", i16.prog_count); end
        vectors++; if (st16 !== INIT) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", st16, INIT); end
        release_reset(c16, c12);
        vectors++; if (c16 != 16) begin miscompares++; $display("FAIL init_cycles16: got %0d want 16", c16); end
        vectors++; if (c12 != 12) begin miscompares++; $display("FAIL init_cycles12: got %0d want 12", c12); end
        vectors++; if (i16.init_done !== 1'b1) begin miscompares++; $display("FAIL init_done: got %b want 1", i16.init_done); end
        vectors++; if (i16.fetch_ready !== 1'b1) begin miscompares++; $display("FAIL init_ready: got %b want 1", i16.fetch_ready); end
    endtask

    task automatic test_back_to_back;
        fetch16(4'd5);
        vectors++; if (i16.fetch_valid !== 1'b1 || i16.fetch_instr !== 8'd64) begin miscompares++; $display("FAIL b2b_5: got v=%b %0d want v=1 64", i16.fetch_valid, i16.fetch_instr); end
        fetch16(4'd6);
        vectors++; if (i16.fetch_valid !== 1'b1 || i16.fetch_instr !== 8'd128) begin miscompares++; $display("FAIL b2b_6: got v=%b %0d want v=1 128", i16.fetch_valid, i16.fetch_instr); end
        idle_all;
        @(posedge clk); #1;
        vectors++; if (i16.fetch_valid !== 1'b0 || i16.fetch_instr !== 8'd128) begin miscompares++; $display("FAIL b2b_hold: got v=%b %0d want v=0 128", i16.fetch_valid, i16.fetch_instr); end
    endtask

    task automatic test_load;
        logic [7:0] exp_w [4];
        exp_w[0] = 8'hA1; exp_w[1] = 8'hA2; exp_w[2] = 8'hA3; exp_w[3] = 8'd16;
        prog_begin;
        vectors++; if (i16.prog_busy !== 1'b1 || st16 !== LOAD) begin miscompares++; $display("FAIL load_enter: got busy=%b st=%0d want busy=1 st=%0d", i16.prog_busy, st16, LOAD); end
        prog_write(8'hA1, 0);
        prog_write(8'hA2, 0);
        prog_write(8'hA3, 1);
        idle_all;
        vectors++; if (i16.prog_count !== 5'd3) begin miscompares++; $display("FAIL load_count: got %0d want 3", i16.prog_count); end
        vectors++; if (i16.fetch_ready !== 1'b1 || i16.prog_busy !== 1'b0) begin miscompares++; $display("FAIL load_exit: got ready=%b busy=%b want 1 0", i16.fetch_ready, i16.prog_busy); end
        for (int a = 0; a < 4; a++) begin
            fetch16(4'(a));
            vectors++; if (i16.fetch_valid !== 1'b1 || i16.fetch_instr !== exp_w[a]) begin miscompares++; $display("FAIL load_fetch%0d: got v=%b %h want v=1 %h", a, i16.fetch_valid, i16.fetch_instr, exp_w[a]); end
        end
        idle_all;
    endtask

    task automatic test_out_of_range;
        fetch12(4'd13);
        vectors++; if (i12.fetch_valid !== 1'b1 || i12.fetch_err !== 1'b1 || i12.fetch_instr !== 8'd0) begin miscompares++; $display("FAIL oob_13: got v=%b e=%b %0d want 1 1 0", i12.fetch_valid, i12.fetch_err, i12.fetch_instr); end
        fetch12(4'd11);
        vectors++; if (i12.fetch_valid !== 1'b1 || i12.fetch_err !== 1'b0 || i12.fetch_instr !== 8'd200) begin miscompares++; $display("FAIL oob_11: got v=%b e=%b %0d want 1 0 200", i12.fetch_valid, i12.fetch_err, i12.fetch_instr); end
        fetch12(4'd12);
        vectors++; if (i12.fetch_err !== 1'b1 || i12.fetch_instr !== 8'd0) begin miscompares++; $display("FAIL oob_12: got e=%b %0d want 1 0", i12.fetch_err, i12.fetch_instr); end
        idle_all;
    endtask

    task automatic test_saturate;
        prog_begin;
        for (int i = 0; i < 20; i++) begin
            prog_write(8'h30 + 8'(i), (i == 19));
            if (i == 17) begin
                vectors++; if (i16.prog_count !== 5'd16) begin miscompares++; $display("FAIL sat_mid: got %0d want 16", i16.prog_count); end
            end
        end
        idle_all;
        vectors++; if (i16.prog_count !== 5'd16 || st16 !== RUN) begin miscompares++; $display("FAIL sat_end: got cnt=%0d st=%0d want 16 %0d", i16.prog_count, st16, RUN); end
        fetch16(4'd15);
        vectors++; if (i16.fetch_instr !== 8'h3F) begin miscompares++; $display("FAIL sat_fetch15: got %h want 3f", i16.fetch_instr); end
        fetch16(4'd0);
        vectors++; if (i16.fetch_instr !== 8'h30) begin miscompares++; $display("FAIL sat_fetch0: got %h want 30", i16.fetch_instr); end
        idle_all;
    endtask

    task automatic test_reset_mid_load;
        prog_begin;
        prog_write(8'h55, 0);
        prog_write(8'h66, 0);
        @(negedge clk);
        rst = 1; i16.prog_wr = 0;
        #1;
        vectors++; if (st16 !== INIT || i16.prog_busy !== 1'b1 || i16.prog_count !== 5'd0 || i16.init_done !== 1'b0) begin miscompares++; $display("FAIL midrst: got st=%0d busy=%b cnt=%0d done=%b want %0d 1 0 0", st16, i16.prog_busy, i16.prog_count, i16.init_done, INIT); end
        release_reset(c16, c12);
        vectors++; if (c16 != 16) begin miscompares++; $display("FAIL midrst_cycles: got %0d want 16", c16); end
        fetch16(4'd0);
        vectors++; if (i16.fetch_valid !== 1'b1 || i16.fetch_instr !== 8'd0) begin miscompares++; $display("FAIL midrst_f0: got v=%b %h want 1 00", i16.fetch_valid, i16.fetch_instr); end
        fetch16(4'd1);
        vectors++; if (i16.fetch_valid !== 1'b1 || i16.fetch_instr !== 8'd2) begin miscompares++; $display("FAIL midrst_f1: got v=%b %h want 1 02", i16.fetch_valid, i16.fetch_instr); end
        idle_all;
    endtask

    task automatic test_start_priority;
        @(negedge clk);
        i16.prog_start = 1; i16.fetch_req = 1; i16.fetch_addr = 4'd5;
        @(posedge clk); #1;
        vectors++; if (i16.fetch_valid !== 1'b0 || st16 !== LOAD) begin miscompares++; $display("FAIL prio: got v=%b st=%0d want 0 %0d", i16.fetch_valid, st16, LOAD); end
        @(negedge clk);
        i16.prog_start = 0; i16.fetch_req = 0; i16.prog_last = 1; i16.prog_wr = 0;
        @(posedge clk); #1;
        vectors++; if (st16 !== LOAD || i16.prog_count !== 5'd0) begin miscompares++; $display("FAIL last_alone: got st=%0d cnt=%0d want %0d 0", st16, i16.prog_count, LOAD); end
        prog_write(8'h77, 1);
        idle_all;
        vectors++; if (st16 !== RUN || i16.prog_count !== 5'd1) begin miscompares++; $display("FAIL prio_exit: got st=%0d cnt=%0d want %0d 1", st16, i16.prog_count, RUN); end
        fetch16(4'd0);
        vectors++; if (i16.fetch_instr !== 8'h77) begin miscompares++; $display("FAIL prio_f0: got %h want 77", i16.fetch_instr); end
        fetch16(4'd5);
        vectors++; if (i16.fetch_instr !== 8'd64) begin miscompares++; $display("FAIL prio_f5: got %0d want 64", i16.fetch_instr); end
        idle_all;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1;
        i16.fetch_req = 0; i16.fetch_addr = '0; i16.prog_start = 0; i16.prog_wr = 0; i16.prog_data = '0; i16.prog_last = 0;
        i12.fetch_req = 0; i12.fetch_addr = '0; i12.prog_start = 0; i12.prog_wr = 0; i12.prog_data = '0; i12.prog_last = 0;
        test_reset;
        test_back_to_back;
        test_load;
        test_out_of_range;
        test_saturate;
        test_reset_mid_load;
        test_start_priority;
        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
